// File: rtl/stump_shift_seq_pkg.sv
// Shared constants and encodings for the Stump multi-cycle shift sequencer.
package stump_shift_seq_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ASR  = 2'b01,
    OP_ROR  = 2'b10,
    OP_RRC  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/stump_shift_seq_shift.sv
// Stump one-bit shift stage: applies a single ASR/ROR/RRC step to a word and carry.
module stump_shift
  import stump_shift_seq_pkg::*;
(
  input  logic [WIDTH-1:0] operand_a,
  input  logic             c_in,
  input  logic [1:0]       shift_op,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  // One shift step; OP_NONE passes value and carry through untouched.
  always_comb begin
    result = operand_a;
    c_out  = c_in;
    case (shift_op)
      OP_ASR: begin
        result = {operand_a[WIDTH-1], operand_a[WIDTH-1:1]};
        c_out  = operand_a[0];
      end
      OP_ROR: begin
        result = {operand_a[0], operand_a[WIDTH-1:1]};
        c_out  = operand_a[0];
      end
      OP_RRC: begin
        result = {c_in, operand_a[WIDTH-1:1]};
        c_out  = operand_a[0];
      end
      default: begin
        result = operand_a;
        c_out  = c_in;
      end
    endcase
  end

endmodule

// File: rtl/stump_shift_seq.sv
// Multi-cycle shift sequencer: iterates the one-bit Stump shift step `count`
// times, feeding result and carry back each cycle, with start/busy/done handshake.
module stump_shift_seq
  import stump_shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       shift_op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] operand,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  shift_op_e        op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] step_v;
  logic             step_c;

  // The step unit always works on the registered word/carry with the latched op.
  stump_shift u_step (
    .operand_a (result_q),
    .c_in      (carry_q),
    .shift_op  (op_q),
    .result    (step_v),
    .c_out     (step_c)
  );

  // Next-state, datapath and counter update.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    op_d     = op_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          result_d = operand;
          carry_d  = c_in;
          op_d     = shift_op_e'(shift_op);
          rem_d    = count;
          // Nothing to iterate: report completion on the very next cycle.
          if ((count == '0) || (shift_op_e'(shift_op) == OP_NONE)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        result_d = step_v;
        carry_d  = step_c;
        rem_d    = rem_q - 1'b1;
        // Leaving at 1 keeps the counter from ever underflowing.
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_NONE;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_out  = carry_q;

endmodule

// File: tb/tb_stump_shift_seq.sv
// Self-checking bench for stump_shift_seq: directed test-plan cases plus random
// operations, compared against a closed-form shift model.
module tb_stump_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  shift_op = 2'b00;
  logic [3:0]  count = 4'd0;
  logic [15:0] operand = 16'h0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  // next-operation inputs used when chaining in the DONE cycle
  logic [1:0]  nx_op;
  logic [3:0]  nx_cnt;
  logic [15:0] nx_opnd;
  logic        nx_cin;

  stump_shift_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_op(shift_op),
    .count(count), .operand(operand), .c_in(c_in),
    .busy(busy), .done(done), .result(result), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Closed-form model: the value after n whole steps.
  // ASR = arithmetic shift, ROR = 16-bit rotate, RRC = 17-bit rotate of {C,V}.
  task automatic model(input logic [1:0] op, input int n, input logic [15:0] v,
                       input logic c, output logic [15:0] r, output logic co);
    logic [16:0] x;
    logic [16:0] rot;
    r  = v;
    co = c;
    if (n > 0) begin
      case (op)
        2'b01: begin r = 16'($signed(v) >>> n); co = v[n-1]; end
        2'b10: begin r = 16'((v >> n) | (v << (16 - n))); co = v[n-1]; end
        2'b11: begin
          x   = {c, v};
          rot = 17'((x >> n) | (x << (17 - n)));
          r   = rot[15:0];
          co  = rot[16];
        end
        default: begin r = v; co = c; end
      endcase
    end
  endtask

  // Runs one operation. launched=1 means start was already raised by the
  // previous op's DONE cycle. poke>0 raises a bogus start in that cycle.
  // chain=1 raises start with nx_* during the DONE cycle.
  task automatic run_op(input logic [1:0] op, input logic [3:0] cnt,
                        input logic [15:0] opnd, input logic cin,
                        input int poke, input bit launched, input bit chain);
    int neff;
    logic [15:0] er;
    logic        ec;
    if (!launched) begin
      @(negedge clk);
      start = 1'b1; shift_op = op; count = cnt; operand = opnd; c_in = cin;
    end
    neff = (op == 2'b00 || cnt == 4'd0) ? 0 : int'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
    shift_op = 2'($urandom); count = 4'($urandom);
    operand = 16'($urandom); c_in = 1'($urandom);
    for (int k = 1; k <= neff + 1; k++) begin
      @(negedge clk);
      model(op, k - 1, opnd, cin, er, ec);
      check($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= neff));
      check($sformatf("done_c%0d", k), 32'(done), 32'(k == neff + 1));
      check($sformatf("result_c%0d", k), 32'(result), 32'(er));
      check($sformatf("cout_c%0d", k), 32'(c_out), 32'(ec));
      start = 1'b0;
      if (k == poke && k <= neff) begin
        start = 1'b1; shift_op = 2'($urandom); count = 4'($urandom);
        operand = ~opnd; c_in = ~cin;
      end
      if (k == neff + 1 && chain) begin
        start = 1'b1; shift_op = nx_op; count = nx_cnt; operand = nx_opnd; c_in = nx_cin;
      end
    end
    $display("op=%0d cnt=%0d operand=0x%04h c_in=%0d -> result=0x%04h c_out=%0d done_cycle=%0d",
             op, cnt, opnd, cin, result, c_out, neff + 1);
    if (!chain) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_done", 32'(done), 32'h0);
      check("idle_result_hold", 32'(result), 32'(er));
      check("idle_cout_hold", 32'(c_out), 32'(ec));
    end
  endtask

  initial begin
    // reset state
    #12;
    check("rst_result", 32'(result), 32'h0);
    check("rst_cout", 32'(c_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed test-plan cases
    run_op(2'b01, 4'd3, 16'h8004, 1'b0, 0, 1'b0, 1'b0);
    run_op(2'b10, 4'd4, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(2'b11, 4'd2, 16'h0003, 1'b1, 0, 1'b0, 1'b0);
    run_op(2'b00, 4'd7, 16'h1234, 1'b1, 0, 1'b0, 1'b0);
    run_op(2'b01, 4'd0, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
    run_op(2'b10, 4'd15, 16'hA5C3, 1'b0, 0, 1'b0, 1'b0);
    run_op(2'b11, 4'd15, 16'h8001, 1'b1, 0, 1'b0, 1'b0);

    // start during SHIFT ignored, then back-to-back launch from DONE
    nx_op = 2'b11; nx_cnt = 4'd5; nx_opnd = 16'h1357; nx_cin = 1'b1;
    run_op(2'b01, 4'd6, 16'hC0DE, 1'b0, 2, 1'b0, 1'b1);
    run_op(nx_op, nx_cnt, nx_opnd, nx_cin, 0, 1'b1, 1'b0);

    // random operations, some chained back-to-back
    begin
      logic [1:0] op; logic [3:0] cnt; logic [15:0] v; logic c; bit launched;
      launched = 1'b0;
      op = 2'($urandom); cnt = 4'($urandom); v = 16'($urandom); c = 1'($urandom);
      for (int i = 0; i < 24; i++) begin
        bit ch;
        ch = (i < 23) && ($urandom_range(0, 2) == 0);
        nx_op = 2'($urandom); nx_cnt = 4'($urandom);
        nx_opnd = 16'($urandom); nx_cin = 1'($urandom);
        run_op(op, cnt, v, c, int'($urandom_range(0, 4)), launched, ch);
        launched = ch;
        if (ch) begin
          op = nx_op; cnt = nx_cnt; v = nx_opnd; c = nx_cin;
        end else begin
          op = 2'($urandom); cnt = 4'($urandom); v = 16'($urandom); c = 1'($urandom);
        end
      end
    end

    // reset mid-operation: ROR count 10, reset asserted in cycle 4
    @(negedge clk);
    start = 1'b1; shift_op = 2'b10; count = 4'd10; operand = 16'h00F1; c_in = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_cout", 32'(c_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    $display("reset asserted mid-SHIFT: result=0x%04h c_out=%0d busy=%0d done=%0d",
             result, c_out, busy, done);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen_done, seen_busy;
      seen_done = 0; seen_busy = 0;
      repeat (16) begin
        @(negedge clk);
        if (done) seen_done++;
        if (busy) seen_busy++;
      end
      check("post_rst_no_done", 32'(seen_done), 32'h0);
      check("post_rst_no_busy", 32'(seen_busy), 32'h0);
      check("post_rst_result", 32'(result), 32'h0);
    end
    run_op(2'b01, 4'd1, 16'h8001, 1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
